// File: rtl/lamp_guard.sv
// Safety stage between the traffic-light controller and the physical lamps.
// Forwards legal patterns, trips to a latched flashing-red fault on illegal or stuck input.
`timescale 1ns/1ps

module lamp_guard #(
    parameter int STARTUP    = 8,
    parameter int DEBOUNCE   = 2,
    parameter int FLASH_HALF = 4,
    parameter int WDOG       = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] light,
    input  logic       clr_fault,
    output logic [5:0] lamp,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] dbg_state
);

    localparam logic [5:0] ALL_RED = 6'b100100;

    localparam int HW = $clog2(STARTUP + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int WW = $clog2(WDOG + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(STARTUP - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG - 1);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_ENC   = 2'd1;
    localparam logic [1:0] CODE_ROW   = 2'd2;
    localparam logic [1:0] CODE_STUCK = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_PASS  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state;
    logic [5:0]      light_q;
    logic [5:0]      prev_q;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   ill_cnt;
    logic [WW-1:0]   wd_cnt;
    logic [FW-1:0]   flash_cnt;
    logic            phase;

    logic [1:0]      bad_code;
    logic            illegal;
    logic            unchanged;

    function automatic logic onehot3(input logic [2:0] g);
        return (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
    endfunction

    function automatic logic [5:0] flash_pat(input logic on);
        return {on, 2'b00, on, 2'b00};
    endfunction

    // Encoding errors outrank the right-of-way check: a malformed group says nothing reliable about red.
    always_comb begin
        bad_code = CODE_NONE;
        if (!onehot3(light_q[5:3]) || !onehot3(light_q[2:0])) begin
            bad_code = CODE_ENC;
        end else if (!(light_q[5] || light_q[2])) begin
            bad_code = CODE_ROW;
        end
    end

    assign illegal   = (bad_code != CODE_NONE);
    assign unchanged = (light_q == prev_q);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HOLD;
            light_q    <= ALL_RED;
            prev_q     <= ALL_RED;
            lamp       <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            hold_cnt   <= '0;
            ill_cnt    <= '0;
            wd_cnt     <= '0;
            flash_cnt  <= '0;
            phase      <= 1'b1;
        end else begin
            light_q <= light;
            prev_q  <= light_q;

            case (state)
                S_HOLD: begin
                    lamp    <= ALL_RED;
                    ill_cnt <= '0;
                    wd_cnt  <= '0;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= S_PASS;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                S_PASS: begin
                    if ((illegal && (ill_cnt == DEB_LAST)) ||
                        (!illegal && unchanged && (wd_cnt == WDOG_LAST))) begin
                        // Trip: illegal code wins automatically since the stuck trip needs legal input.
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= illegal ? bad_code : CODE_STUCK;
                        lamp       <= ALL_RED;
                        phase      <= 1'b1;
                        flash_cnt  <= '0;
                        ill_cnt    <= '0;
                        wd_cnt     <= '0;
                    end else begin
                        lamp    <= light_q;
                        ill_cnt <= illegal ? ill_cnt + 1'b1 : '0;
                        if (!unchanged) begin
                            wd_cnt <= '0;
                        end else if (wd_cnt != WDOG_LAST) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end

                S_FAULT: begin
                    ill_cnt <= '0;
                    wd_cnt  <= '0;
                    if (clr_fault && !illegal) begin
                        state      <= S_HOLD;
                        fault      <= 1'b0;
                        fault_code <= CODE_NONE;
                        lamp       <= ALL_RED;
                        hold_cnt   <= '0;
                        phase      <= 1'b1;
                        flash_cnt  <= '0;
                    end else if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        phase     <= ~phase;
                        lamp      <= flash_pat(~phase);
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                        lamp      <= flash_pat(phase);
                    end
                end

                default: begin
                    state    <= S_HOLD;
                    lamp     <= ALL_RED;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
